md4_pad: RTL

- Upstream neighbour of the MD4 compression core.
- Accepts a message as a byte stream with a valid/ready handshake and applies MD4 padding: 0x80, zero fill, and a 64-bit little-endian bit length.
- Emits 512-bit blocks whose word and byte layout matches the core's `message` input.
- Multi-block messages are emitted in order; the final block is flagged with `blk_last`.

---
 rtl/md4_pad.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/md4_pad.sv
// Purpose : MD4 message padder; turns a byte stream into 512-bit blocks in the core's word/byte layout.
// Latency : block valid 1 cycle after the 64th byte, 2 cycles after the in_last beat; a tail block adds 1.
// Backpressure: in_ready is low whenever a block is pending; blk_data/blk_last hold until blk_ready.
//
// Ports: clk, reset_n (async, active-low); in_valid/in_ready/in_data/in_keep/in_last byte
// stream in; blk_valid/blk_ready/blk_data/blk_last block out.
// Optional: define MD4_PAD_OVF_EN to add the sticky len_ovf output (byte counter overflow).
module md4_pad #(
   parameter int LEN_W = 61
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [7:0]   in_data,
   input  logic         in_keep,
   input  logic         in_last,
   output logic         blk_valid,
   input  logic         blk_ready,
   output logic [511:0] blk_data,
   output logic         blk_last
`ifdef MD4_PAD_OVF_EN
   ,
   output logic         len_ovf
`endif
);

   typedef enum logic [1:0] {S_FILL, S_PAD, S_OUT, S_TAIL} state_e;
   typedef enum logic [1:0] {T_NONE, T_ZERO, T_MARK} tail_e;

   state_e             state_q, state_d;
   tail_e              tail_q, tail_d;
   logic [6:0]         pos_q, pos_d;      // 0..64, next byte slot
   logic [LEN_W-1:0]   cnt_q, cnt_d;      // message bytes so far
   logic [511:0]       buf_q, buf_d;
   logic               blk_last_q, blk_last_d;
   logic               in_ready_q, in_ready_d;
   logic               beat;
   logic [63:0]        len64;

   // Byte j lives in word j/4, lane j%4; byte 0 of a word is its least significant lane.
   function automatic logic [8:0] byte_lsb(input logic [5:0] j);
      return 9'(480 - 32 * int'(j[5:2]) + 8 * int'(j[1:0]));
   endfunction

   // Little-endian bit length into bytes 56..63.
   function automatic logic [511:0] put_len(input logic [511:0] b, input logic [63:0] len);
      logic [511:0] r;
      r = b;
      for (int k = 0; k < 8; k++) begin
         r[byte_lsb(6'(56 + k)) +: 8] = len[8*k +: 8];
      end
      return r;
   endfunction

   assign beat      = in_valid && in_ready_q;
   assign len64     = 64'({cnt_q, 3'b000});
   assign in_ready  = in_ready_q;
   assign blk_valid = (state_q == S_OUT);
   assign blk_data  = buf_q;
   assign blk_last  = blk_last_q;

   always_comb begin
      state_d    = state_q;
      tail_d     = tail_q;
      pos_d      = pos_q;
      cnt_d      = cnt_q;
      buf_d      = buf_q;
      blk_last_d = blk_last_q;
      case (state_q)
         S_FILL: begin
            if (beat) begin
               if (in_keep) begin
                  buf_d[byte_lsb(pos_q[5:0]) +: 8] = in_data;
                  pos_d = pos_q + 7'd1;
                  cnt_d = cnt_q + LEN_W'(1);
               end
               if (in_last) begin
                  state_d = S_PAD;
               end else if (pos_d == 7'd64) begin
                  state_d    = S_OUT;
                  blk_last_d = 1'b0;
               end
            end
         end
         S_PAD: begin
            // 0x80 marker at pos, zeros after; when the length fits it overwrites bytes 56..63.
            for (int j = 0; j < 64; j++) begin
               if (7'(j) == pos_q) begin
                  buf_d[byte_lsb(6'(j)) +: 8] = 8'h80;
               end else if (7'(j) > pos_q) begin
                  buf_d[byte_lsb(6'(j)) +: 8] = 8'h00;
               end
            end
            if (pos_q <= 7'd55) begin
               buf_d      = put_len(buf_d, len64);
               blk_last_d = 1'b1;
               tail_d     = T_NONE;
            end else if (pos_q == 7'd64) begin
               blk_last_d = 1'b0;
               tail_d     = T_MARK;
            end else begin
               blk_last_d = 1'b0;
               tail_d     = T_ZERO;
            end
            state_d = S_OUT;
         end
         S_OUT: begin
            if (blk_ready) begin
               if (blk_last_q) begin
                  pos_d      = '0;
                  cnt_d      = '0;
                  buf_d      = '0;
                  blk_last_d = 1'b0;
                  state_d    = S_FILL;
               end else if (tail_q != T_NONE) begin
                  state_d = S_TAIL;
               end else begin
                  pos_d   = '0;
                  buf_d   = '0;
                  state_d = S_FILL;
               end
            end
         end
         S_TAIL: begin
            // Extra block: marker only if the message filled the previous block exactly.
            buf_d = '0;
            if (tail_q == T_MARK) begin
               buf_d[487:480] = 8'h80;
            end
            buf_d      = put_len(buf_d, len64);
            blk_last_d = 1'b1;
            tail_d     = T_NONE;
            state_d    = S_OUT;
         end
         default: state_d = S_FILL;
      endcase
      in_ready_d = (state_d == S_FILL);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= S_FILL;
         tail_q     <= T_NONE;
         pos_q      <= '0;
         cnt_q      <= '0;
         buf_q      <= '0;
         blk_last_q <= 1'b0;
         in_ready_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         tail_q     <= tail_d;
         pos_q      <= pos_d;
         cnt_q      <= cnt_d;
         buf_q      <= buf_d;
         blk_last_q <= blk_last_d;
         in_ready_q <= in_ready_d;
      end
   end

`ifdef MD4_PAD_OVF_EN
   logic len_ovf_q, len_ovf_d;

   always_comb begin
      len_ovf_d = len_ovf_q;
      if (beat && in_keep && (&cnt_q)) begin
         len_ovf_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         len_ovf_q <= 1'b0;
      end else begin
         len_ovf_q <= len_ovf_d;
      end
   end

   assign len_ovf = len_ovf_q;
`endif

endmodule
